// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - raw button to clean level plus rise/fall pulses and press counter
// Two-flop synchronizer feeding a four-state stable-sample debounce FSM.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    output logic             btn_level,
    output logic             btn_rise,
    output logic             btn_fall,
    output logic [CNT_W-1:0] press_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TGT  = CW'(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] PRESS_ONE = CNT_W'(1);

    localparam logic [1:0] IDLE_LO  = 2'd0;
    localparam logic [1:0] CHECK_HI = 2'd1;
    localparam logic [1:0] IDLE_HI  = 2'd2;
    localparam logic [1:0] CHECK_LO = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    cnt_inc;
    logic             level_d;
    logic             rise_d;
    logic             fall_d;
    logic [CNT_W-1:0] count_d;

    // Only the last synchronizer stage is ever looked at by the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = btn_level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        count_d = press_count;
        case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = CHECK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            CHECK_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_inc == CNT_TGT) begin
                    state_d = IDLE_HI;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    count_d = press_count + PRESS_ONE;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = CHECK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            CHECK_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_inc == CNT_TGT) begin
                    state_d = IDLE_LO;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Pulses are recomputed every cycle, so they can only last one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE_LO;
            cnt_q       <= CNT_ZERO;
            btn_level   <= 1'b0;
            btn_rise    <= 1'b0;
            btn_fall    <= 1'b0;
            press_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_level   <= level_d;
            btn_rise    <= rise_d;
            btn_fall    <= fall_d;
            press_count <= count_d;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       btn_level;
    logic       btn_rise;
    logic       btn_fall;
    logic [7:0] press_count;

    int n_total;
    int n_bad;
    int rise_total;
    int both_high;

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (btn_rise === 1'b1) rise_total++;
        if (btn_rise === 1'b1 && btn_fall === 1'b1) both_high++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_release();
        btn_in = 1'b1;
        repeat (6) tick();
        btn_in = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rise_total = 0;
        both_high  = 0;
        rst        = 1'b1;
        btn_in     = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_val("rst_level", {31'd0, btn_level}, 32'd0);
        check_val("rst_rise", {31'd0, btn_rise}, 32'd0);
        check_val("rst_fall", {31'd0, btn_fall}, 32'd0);
        check_val("rst_count", {24'd0, press_count}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        check_val("idle_level", {31'd0, btn_level}, 32'd0);

        // glitch: high for three edges only
        btn_in = 1'b1;
        repeat (3) tick();
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("glitch_level", {31'd0, btn_level}, 32'd0);
            check_val("glitch_rise", {31'd0, btn_rise}, 32'd0);
        end
        check_val("glitch_count", {24'd0, press_count}, 32'd0);

        // clean press
        btn_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val("press_early_rise", {31'd0, btn_rise}, 32'd0);
            check_val("press_early_level", {31'd0, btn_level}, 32'd0);
        end
        tick();
        check_val("press_rise", {31'd0, btn_rise}, 32'd1);
        check_val("press_level", {31'd0, btn_level}, 32'd1);
        check_val("press_count", {24'd0, press_count}, 32'd1);
        tick();
        check_val("press_rise_end", {31'd0, btn_rise}, 32'd0);
        check_val("press_level_hold", {31'd0, btn_level}, 32'd1);

        // release
        btn_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val("rel_early_fall", {31'd0, btn_fall}, 32'd0);
            check_val("rel_early_level", {31'd0, btn_level}, 32'd1);
        end
        tick();
        check_val("rel_fall", {31'd0, btn_fall}, 32'd1);
        check_val("rel_level", {31'd0, btn_level}, 32'd0);
        check_val("rel_count", {24'd0, press_count}, 32'd1);
        tick();
        check_val("rel_fall_end", {31'd0, btn_fall}, 32'd0);

        // bounce 1,0,1,0 then held 1
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check_val("bounce_rise_early", {31'd0, btn_rise}, 32'd0);
        end
        btn_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val("bounce_rise_wait", {31'd0, btn_rise}, 32'd0);
        end
        tick();
        check_val("bounce_rise", {31'd0, btn_rise}, 32'd1);
        check_val("bounce_count", {24'd0, press_count}, 32'd2);
        btn_in = 1'b0;
        repeat (8) tick();
        check_val("bounce_rel_level", {31'd0, btn_level}, 32'd0);

        // wrap: fresh reset then 256 presses
        rst = 1'b0;
        #1;
        check_val("wrap_rst_count", {24'd0, press_count}, 32'd0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        press_release();
        check_val("wrap_first", {24'd0, press_count}, 32'd1);
        repeat (254) press_release();
        check_val("wrap_255", {24'd0, press_count}, 32'd255);
        press_release();
        check_val("wrap_256", {24'd0, press_count}, 32'd0);

        // reset mid-check with a nonzero count to observe
        press_release();
        check_val("mid_pre_count", {24'd0, press_count}, 32'd1);
        btn_in = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check_val("mid_rst_count", {24'd0, press_count}, 32'd0);
        check_val("mid_rst_level", {31'd0, btn_level}, 32'd0);
        check_val("mid_rst_rise", {31'd0, btn_rise}, 32'd0);
        repeat (2) tick();
        check_val("mid_hold_rise", {31'd0, btn_rise}, 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val("mid_wait_rise", {31'd0, btn_rise}, 32'd0);
        end
        tick();
        check_val("mid_rise", {31'd0, btn_rise}, 32'd1);
        check_val("mid_count", {24'd0, press_count}, 32'd1);
        tick();
        check_val("mid_rise_end", {31'd0, btn_rise}, 32'd0);

        check_val("rise_total", rise_total, 32'd260);
        check_val("both_high", both_high, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
